// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares one register-file write port between ALU and a FIFO-buffered memory writeback,
// with a starvation guard for the FIFO and a RAW stall against uncommitted writes.
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           alu_valid,
  output logic                           alu_ready,
  input  logic [ADDRESS_WIDTH-1:0]       alu_rd,
  input  logic [DATA_WIDTH-1:0]          alu_data,
  input  logic                           mem_valid,
  output logic                           mem_ready,
  input  logic [ADDRESS_WIDTH-1:0]       mem_rd,
  input  logic [DATA_WIDTH-1:0]          mem_data,
  output logic                           WE3,
  output logic [ADDRESS_WIDTH-1:0]       wr_addr,
  output logic [DATA_WIDTH-1:0]          WD3,
  input  logic [ADDRESS_WIDTH-1:0]       rs1,
  input  logic [ADDRESS_WIDTH-1:0]       rs2,
  output logic                           stall,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic {NORMAL, FORCE} state_t;
  state_t state, state_n;
  logic [ADDRESS_WIDTH-1:0] q_rd [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [SW-1:0] starve;
  logic alu_grant, push, pop, starve_hit;
  assign mem_ready  = !rst && fifo_count < CW'(FIFO_DEPTH);
  assign alu_grant  = alu_ready && alu_valid && alu_rd != '0;
  assign push       = mem_ready && mem_valid && mem_rd != '0;
  assign pop        = !rst && fifo_count != '0 && !alu_grant;
  assign starve_hit = alu_grant && fifo_count != '0 && starve == SW'(STARVE_LIMIT - 1);
  always_ff @(posedge clk)
    state <= rst ? NORMAL : state_n;
  always_comb
    state_n = state == FORCE ? NORMAL : starve_hit ? FORCE : NORMAL;
  always_comb
    alu_ready = !rst && state == NORMAL;
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wp]   <= mem_rd;
      q_data[wp] <= mem_data;
    end
    if (rst) begin
      wp         <= '0;
      rp         <= '0;
      fifo_count <= '0;
      starve     <= '0;
    end else begin
      wp         <= wp + PW'(push);
      rp         <= rp + PW'(pop);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      starve     <= (pop || fifo_count == '0 || starve_hit) ? '0 : starve + SW'(alu_grant);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      WE3     <= 1'b0;
      wr_addr <= '0;
      WD3     <= '0;
    end else begin
      WE3 <= alu_grant || pop;
      if (alu_grant) begin
        wr_addr <= alu_rd;
        WD3     <= alu_data;
      end else if (pop) begin
        wr_addr <= q_rd[rp];
        WD3     <= q_data[rp];
      end
    end
  end
  // The in-flight WE3 write counts as uncommitted: the register file reads combinationally.
  always_comb begin
    stall = WE3 && ((rs1 != '0 && rs1 == wr_addr) || (rs2 != '0 && rs2 == wr_addr));
    for (int i = 0; i < FIFO_DEPTH; i++)
      if (CW'(i) < fifo_count && ((rs1 != '0 && rs1 == q_rd[rp + PW'(i)]) || (rs2 != '0 && rs2 == q_rd[rp + PW'(i)])))
        stall = 1'b1;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scenario tasks with hand-computed expectations for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  logic clk = 0, rst = 1;
  logic alu_valid = 0, alu_ready, mem_valid = 0, mem_ready, WE3, stall;
  logic [4:0] alu_rd = 0, mem_rd = 0, wr_addr, rs1 = 0, rs2 = 0;
  logic [31:0] alu_data = 0, mem_data = 0, WD3;
  logic [1:0] fifo_count;
  int checks = 0, errors = 0;
  regfile_wb_arbiter dut (
    .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .WE3(WE3), .wr_addr(wr_addr), .WD3(WD3), .rs1(rs1), .rs2(rs2), .stall(stall), .fifo_count(fifo_count)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1;
    tick();
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL rst_alu_ready: got %0b expected 0", alu_ready); end
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_ready: got %0b expected 0", mem_ready); end
    tick();
    rst = 0;
    #1;
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL rst_we3: got %0b expected 0", WE3); end
    checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL rst_wr_addr: got %0d expected 0", wr_addr); end
    checks++; if (WD3 !== 32'd0) begin errors++; $display("FAIL rst_wd3: got %0h expected 0", WD3); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
    checks++; if (mem_ready !== 1'b1 || alu_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got mem %0b alu %0b expected 1 1", mem_ready, alu_ready); end
  endtask
  task automatic test_alu_write();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL alu_ready: got %0b expected 1", alu_ready); end
    tick();
    alu_valid = 0;
    checks++; if (WE3 !== 1'b1 || wr_addr !== 5'd5 || WD3 !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_write: got we %0b addr %0d data %0h expected 1 5 deadbeef", WE3, wr_addr, WD3); end
    tick();
    checks++; if (WE3 !== 1'b0 || wr_addr !== 5'd5) begin errors++; $display("FAIL alu_idle: got we %0b addr %0d expected 0 5", WE3, wr_addr); end
  endtask
  task automatic test_mem_write();
    mem_valid = 1; mem_rd = 7; mem_data = 32'h12;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL mem_ready: got %0b expected 1", mem_ready); end
    tick();
    mem_valid = 0;
    rs1 = 7;
    #1;
    checks++; if (fifo_count !== 2'd1) begin errors++; $display("FAIL mem_count: got %0d expected 1", fifo_count); end
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL mem_no_early_write: got %0b expected 0", WE3); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_fifo_rs1: got %0b expected 1", stall); end
    rs1 = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_rs0: got %0b expected 0", stall); end
    tick();
    checks++; if (WE3 !== 1'b1 || wr_addr !== 5'd7 || WD3 !== 32'h12) begin errors++; $display("FAIL mem_write: got we %0b addr %0d data %0h expected 1 7 12", WE3, wr_addr, WD3); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL mem_drained: got %0d expected 0", fifo_count); end
    rs2 = 7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_we3_rs2: got %0b expected 1", stall); end
    rs2 = 0;
    tick();
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL mem_idle: got %0b expected 0", WE3); end
  endtask
  task automatic test_starvation();
    logic [10:0] exp_rdy = 11'b01111_011111;
    int exp_wa [11] = '{3, 3, 3, 3, 3, 8, 3, 3, 3, 3, 9};
    int exp_wd [11] = '{'h33, 'h33, 'h33, 'h33, 'h33, 'h88, 'h33, 'h33, 'h33, 'h33, 'h99};
    alu_valid = 1; alu_rd = 3; alu_data = 32'h33;
    for (int i = 0; i < 11; i++) begin
      mem_valid = i < 2;
      mem_rd = i == 0 ? 5'd8 : 5'd9;
      mem_data = i == 0 ? 32'h88 : 32'h99;
      #1;
      checks++; if (alu_ready !== exp_rdy[i]) begin errors++; $display("FAIL starve_alu_ready[%0d]: got %0b expected %0b", i, alu_ready, exp_rdy[i]); end
      if (i == 2) begin
        checks++; if (mem_ready !== 1'b0 || fifo_count !== 2'd2) begin errors++; $display("FAIL starve_full: got ready %0b count %0d expected 0 2", mem_ready, fifo_count); end
      end
      tick();
      checks++; if (WE3 !== 1'b1 || wr_addr !== 5'(exp_wa[i]) || WD3 !== 32'(exp_wd[i])) begin errors++; $display("FAIL starve_write[%0d]: got we %0b addr %0d data %0h expected 1 %0d %0h", i, WE3, wr_addr, WD3, exp_wa[i], exp_wd[i]); end
    end
    alu_valid = 0; mem_valid = 0;
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL starve_drained: got %0d expected 0", fifo_count); end
    tick();
  endtask
  task automatic test_rd_zero();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h3;
    mem_valid = 1; mem_rd = 4; mem_data = 32'h44;
    tick();
    mem_valid = 0; alu_rd = 0; alu_data = 32'hBAD;
    #1;
    checks++; if (alu_ready !== 1'b1 || fifo_count !== 2'd1) begin errors++; $display("FAIL rd0_alu: got ready %0b count %0d expected 1 1", alu_ready, fifo_count); end
    tick();
    alu_valid = 0;
    checks++; if (WE3 !== 1'b1 || wr_addr !== 5'd4 || WD3 !== 32'h44) begin errors++; $display("FAIL rd0_pop: got we %0b addr %0d data %0h expected 1 4 44", WE3, wr_addr, WD3); end
    mem_valid = 1; mem_rd = 0; mem_data = 32'h55;
    #1;
    checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL memrd0_ready: got %0b expected 1", mem_ready); end
    tick();
    mem_valid = 0;
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL memrd0_count: got %0d expected 0", fifo_count); end
    tick();
    checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL memrd0_nowrite: got %0b expected 0", WE3); end
  endtask
  task automatic test_back_to_back();
    for (int k = 0; k < 11; k++) begin
      mem_valid = k < 10;
      mem_rd = 5'(10 + k);
      mem_data = 32'h100 + 32'(k);
      tick();
      checks++; if (fifo_count !== (k < 10 ? 2'd1 : 2'd0)) begin errors++; $display("FAIL b2b_count[%0d]: got %0d", k, fifo_count); end
      if (k > 0) begin
        checks++; if (WE3 !== 1'b1 || wr_addr !== 5'(9 + k) || WD3 !== 32'h100 + 32'(k - 1)) begin errors++; $display("FAIL b2b_write[%0d]: got we %0b addr %0d data %0h expected 1 %0d %0h", k, WE3, wr_addr, WD3, 9 + k, 32'h100 + 32'(k - 1)); end
      end
    end
    mem_valid = 0;
    tick();
  endtask
  task automatic test_reset_mid();
    alu_valid = 1; alu_rd = 3; alu_data = 32'h3;
    mem_valid = 1; mem_rd = 20; mem_data = 32'h20;
    tick();
    mem_rd = 21; mem_data = 32'h21;
    tick();
    mem_valid = 0; alu_rd = 6; alu_data = 32'h6;
    rst = 1;
    #1;
    checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL midrst_precount: got %0d expected 2", fifo_count); end
    checks++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got alu %0b mem %0b expected 0 0", alu_ready, mem_ready); end
    tick();
    rst = 0; alu_valid = 0;
    checks++; if (fifo_count !== 2'd0 || WE3 !== 1'b0 || wr_addr !== 5'd0) begin errors++; $display("FAIL midrst_state: got count %0d we %0b addr %0d expected 0 0 0", fifo_count, WE3, wr_addr); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL midrst_ghost[%0d]: got we %0b addr %0d expected we 0", i, WE3, wr_addr); end
    end
  endtask
  initial begin
    test_reset();
    test_alu_write();
    test_mem_write();
    test_starvation();
    test_rd_zero();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (WE3/rd/WD3) between two writeback sources.
- The ALU writeback path has default priority. The memory/long-latency writeback path is buffered in a small FIFO.
- A starvation guard ensures the buffered path eventually drains.
- Also produces a read-after-write stall for the decode stage: it compares rs1/rs2 against all writes not yet committed.

Parameters:
- ADDRESS_WIDTH, 5, register index width (2**ADDRESS_WIDTH registers, x0 hardwired zero).
- DATA_WIDTH, 32, writeback data width.
- FIFO_DEPTH, 2, memory-writeback buffer entries. Power of two, >= 2.
- STARVE_LIMIT, 4, consecutive ALU grants with a non-empty FIFO before a forced FIFO grant. Must be >= 1.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- alu_valid  in  1  ALU result ready to write.
- alu_ready  out  1  ALU write accepted this cycle. ALU must hold rd/data while alu_valid && !alu_ready.
- alu_rd  in  ADDRESS_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- mem_valid  in  1  memory result offered.
- mem_ready  out  1  FIFO can accept.
- mem_rd  in  ADDRESS_WIDTH  memory destination register.
- mem_data  in  DATA_WIDTH  memory result.
- WE3  out  1  register file write enable (registered).
- wr_addr  out  ADDRESS_WIDTH  register file write address (registered).
- WD3  out  DATA_WIDTH  register file write data (registered).
- rs1  in  ADDRESS_WIDTH  decode-stage source 1.
- rs2  in  ADDRESS_WIDTH  decode-stage source 2.
- stall  out  1  RAW hazard against an uncommitted write.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst high at posedge):
  - WE3=0, wr_addr=0, WD3=0, FIFO emptied, fifo_count=0, starve counter=0, state=NORMAL.
  - While rst is high, mem_ready=0 and alu_ready=0.
- Memory acceptance:
  - mem_ready = (fifo_count < FIFO_DEPTH). It depends on registered state only, never on a same-cycle pop.
  - A transfer occurs when mem_valid && mem_ready.
  - mem_rd==0 transfers are accepted and discarded (never enqueued).
- Grant decision each cycle (combinational), two states:
  - NORMAL, ALU request: alu_ready=1. If alu_valid && alu_rd!=0, the ALU write is granted. alu_valid with alu_rd==0 is accepted and dropped, and the port is free this cycle.
  - NORMAL, port free: if the port is free and the FIFO is non-empty, the head is popped and granted.
  - FORCE: alu_ready=0. The FIFO head is popped and granted. Next state is NORMAL.
- Output register: at posedge the granted write is loaded into WE3/wr_addr/WD3. If nothing is granted, WE3=0 and wr_addr/WD3 hold.
- Latency:
  - ALU: 1 cycle from accept to WE3 high.
  - Memory: at least 2 cycles (enqueue edge, then pop edge).
- Starve counter:
  - Increments at posedge when the FIFO is non-empty and the ALU was granted.
  - Clears on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, next state is FORCE and the counter clears.
- FIFO bookkeeping:
  - Simultaneous push and pop keeps the count.
  - Pointers wrap modulo FIFO_DEPTH.
  - Order is strictly FIFO.
- Stall (combinational): asserted if rs1 or rs2 (nonzero) equals any of:
  - the rd of a valid FIFO entry, or
  - wr_addr while WE3=1. This covers write-at-end-of-cycle versus combinational read.
- Stall exclusions: same-cycle mem_rd/alu_rd inputs are not included. rs==0 never stalls.
- Reset mid-operation: queued entries are lost, no partial write is issued, and WE3 is low in the cycle after reset.

Test Plan:
- Reset, then alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> next cycle WE3=1, wr_addr=5, WD3=0xDEADBEEF. Following cycle WE3=0.
- mem_valid=1, mem_rd=7, mem_data=0x12 with ALU idle -> fifo_count=1 after edge, then WE3=1 and wr_addr=7 two cycles after accept. While queued, rs1=7 -> stall=1, and rs1=0 -> stall=0.
- ALU continuously valid (rd=3), two memory writes queued (rd=8, rd=9) -> mem_ready=0 at count 2. After 4 ALU grants, alu_ready=0 for one cycle and rd=8 is written. After 4 more ALU grants, rd=9 is written, in order.
- alu_rd=0 with a queued memory write (rd=4) -> FIFO pops in that same cycle, next cycle wr_addr=4. mem_rd=0 offered -> accepted, fifo_count unchanged, no write.
- Push and pop in the same cycle at count 1 -> fifo_count stays 1, data order preserved across pointer wrap over 10 transfers.
- Assert rst with 2 queued entries and an ALU grant pending -> after reset, fifo_count=0, WE3=0, and no queued write ever appears.
